// File: rtl/uart_tx_sched.sv
// Round-robin UART transmit scheduler: one byte per grant, with timeout abort,
// plus ownership of the baud setting (validated, applied only when idle, then settled).
module uart_tx_sched #(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 32,
    parameter int TMO_CYC    = 250000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*8-1:0]   req_data,
    output logic [NREQ-1:0]     gnt,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_done,
    input  logic                cfg_baud_wr,
    input  logic [16:0]         cfg_baud,
    output logic                cfg_busy,
    output logic                cfg_err,
    output logic                tx_err,
    output logic [16:0]         baud
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (TMO_CYC > SETTLE_CYC) ? TMO_CYC : SETTLE_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [16:0]   BAUD_RST    = 17'd9600;
    localparam logic [PW-1:0] PTR_RST     = PW'(NREQ - 1);
    // The abort fires on the cycle whose increment would bring the count to TMO_CYC-1.
    localparam logic [CW-1:0] TMO_HIT     = CW'(TMO_CYC - 2);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_BAUD  = 2'd3
    } state_t;

    function automatic logic baud_supported(input logic [16:0] b);
        case (b)
            17'd4800, 17'd9600, 17'd14400, 17'd19200,
            17'd38400, 17'd57600, 17'd115200, 17'd128000: baud_supported = 1'b1;
            default:                                      baud_supported = 1'b0;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic [16:0]     pend_q, pend_d;
    logic [16:0]     baud_q, baud_d;
    logic            cfg_err_q, cfg_err_d;
    logic            tx_err_q, tx_err_d;

    logic            win_found_s;
    logic [PW-1:0]   win_idx_s;
    logic [PW-1:0]   cand_s;
    logic [7:0]      win_data_s;

    // Round-robin search: first pending requester above the pointer, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = PW'((int'(ptr_q) + k) % NREQ);
            if (!win_found_s && req[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Byte lane of the current winner.
    always_comb begin
        win_data_s = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == PW'(i)) begin
                win_data_s = req_data[i*8 +: 8];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Next-state, config intake and registered-output computation.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        pend_d     = pend_q;
        baud_d     = baud_q;
        cfg_err_d  = 1'b0;
        tx_err_d   = 1'b0;

        if (cfg_baud_wr && !busy_q) begin
            if (baud_supported(cfg_baud)) begin
                pend_d = cfg_baud;
                busy_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                // In IDLE a set busy flag always means a change is pending, not settling.
                if (busy_q) begin
                    state_d = ST_BAUD;
                    baud_d  = pend_q;
                    cnt_d   = '0;
                end else if (win_found_s) begin
                    state_d    = ST_GRANT;
                    gnt_d      = ONE_HOT0 << win_idx_s;
                    tx_start_d = 1'b1;
                    tx_data_d  = win_data_s;
                    ptr_d      = win_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_d = ST_SEND;
                cnt_d   = '0;
            end
            ST_SEND: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_HIT) begin
                    state_d  = ST_IDLE;
                    tx_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BAUD: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_RST;
            cnt_q      <= '0;
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            pend_q     <= BAUD_RST;
            baud_q     <= BAUD_RST;
            cfg_err_q  <= 1'b0;
            tx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            baud_q     <= baud_d;
            cfg_err_q  <= cfg_err_d;
            tx_err_q   <= tx_err_d;
        end
    end

    assign gnt      = gnt_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign cfg_busy = busy_q;
    assign cfg_err  = cfg_err_q;
    assign tx_err   = tx_err_q;
    assign baud     = baud_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: config table, round-robin table, and
// hand-written sequences for deferral, reset, back-to-back and timeout.
module tb_uart_tx_sched;

    localparam int NREQ       = 4;
    localparam int SETTLE_CYC = 32;
    localparam int TMO_CYC    = 100;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              cfg_baud_wr;
    logic [16:0]       cfg_baud;
    logic              cfg_busy;
    logic              cfg_err;
    logic              tx_err;
    logic [16:0]       baud;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] model_baud;

    uart_tx_sched #(
        .NREQ(NREQ), .SETTLE_CYC(SETTLE_CYC), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .cfg_baud_wr(cfg_baud_wr), .cfg_baud(cfg_baud), .cfg_busy(cfg_busy),
        .cfg_err(cfg_err), .tx_err(tx_err), .baud(baud)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] value;
        logic        valid;
    } cfg_vec_t;

    typedef struct {
        logic [3:0]      req;
        int              n;
        logic [4:0][1:0] idx;
    } rr_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ticks until a grant appears (bounded); tx_done is a one-cycle pulse.
    task automatic wait_gnt(output int t);
        t = 0;
        do begin
            tick();
            tx_done = 1'b0;
            t++;
        end while (gnt == 4'b0000 && t < 60);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_baud = 17'd9600;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_vec_t cfg_tab [8];
        rr_vec_t  rr_tab  [2];
        int       lat;
        logic     bad;

        cfg_tab[0] = '{17'd12345,  1'b0};
        cfg_tab[1] = '{17'd115200, 1'b1};
        cfg_tab[2] = '{17'd0,      1'b0};
        cfg_tab[3] = '{17'd4800,   1'b1};
        cfg_tab[4] = '{17'd131071, 1'b0};
        cfg_tab[5] = '{17'd128000, 1'b1};
        cfg_tab[6] = '{17'd9601,   1'b0};
        cfg_tab[7] = '{17'd9600,   1'b1};
        rr_tab[0]  = '{4'b1111, 5, {2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        rr_tab[1]  = '{4'b1010, 3, {2'd0, 2'd0, 2'd1, 2'd3, 2'd1}};

        rst_n = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
        cfg_baud_wr = 1'b0; cfg_baud = '0; model_baud = 17'd9600;
        tick();
        check("rst_gnt", gnt, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_baud", baud, 9600);
        check("rst_busy", cfg_busy, 0);
        check("rst_errs", {cfg_err, tx_err}, 0);
        rst_n = 1'b1;
        tick();

        // Config table, applied while idle
        for (int i = 0; i < 8; i++) begin
            cfg_baud = cfg_tab[i].value;
            cfg_baud_wr = 1'b1;
            tick();
            cfg_baud_wr = 1'b0;
            check("cfg_err_pulse", cfg_err, !cfg_tab[i].valid);
            check("cfg_busy_rise", cfg_busy, cfg_tab[i].valid);
            tick();
            check("cfg_err_clear", cfg_err, 0);
            if (cfg_tab[i].valid) begin
                model_baud = cfg_tab[i].value;
                check("cfg_baud_applied", baud, model_baud);
                for (int c = 0; c < SETTLE_CYC - 1; c++) tick();
                check("cfg_busy_settle", cfg_busy, 1);
                tick();
                check("cfg_busy_fall", cfg_busy, 0);
            end else begin
                check("cfg_baud_kept", baud, model_baud);
                check("cfg_busy_idle", cfg_busy, 0);
            end
        end

        // Writes while busy are ignored, without cfg_err
        cfg_baud = 17'd57600; cfg_baud_wr = 1'b1;
        tick();
        check("busy_first_write", cfg_busy, 1);
        cfg_baud = 17'd12345;
        tick();
        check("busy_no_err", cfg_err, 0);
        check("busy_baud", baud, 57600);
        cfg_baud = 17'd4800;
        tick();
        cfg_baud_wr = 1'b0;
        for (int c = 0; c < SETTLE_CYC - 1; c++) tick();
        check("busy_fall2", cfg_busy, 0);
        tick();
        check("busy_ignored_baud", baud, 57600);
        check("busy_ignored_busy", cfg_busy, 0);
        model_baud = 17'd57600;

        // Single requester with back-to-back grant latency
        req = 4'b0001; req_data = {24'h0, 8'h5A};
        tick();
        check("single_gnt", gnt, 4'b0001);
        check("single_start", tx_start, 1);
        check("single_data", tx_data, 8'h5A);
        req = 4'b0000;
        tick();
        check("single_gnt_pulse", {gnt, tx_start}, 0);
        check("single_data_hold", tx_data, 8'h5A);
        for (int c = 0; c < 19; c++) tick();
        req = 4'b0001; req_data = {24'h0, 8'h3C};
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("b2b_gap", gnt, 0);
        tick();
        check("b2b_gnt", gnt, 4'b0001);
        check("b2b_data", tx_data, 8'h3C);
        req = 4'b0000;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;

        // Baud write during SEND is deferred; pending req waits for settle
        req = 4'b0100; req_data = {8'h00, 8'h77, 8'h00, 8'h00};
        tick();
        check("defer_gnt", gnt, 4'b0100);
        check("defer_data", tx_data, 8'h77);
        req = 4'b0010; req_data = {8'h00, 8'h77, 8'h99, 8'h00};
        cfg_baud = 17'd115200; cfg_baud_wr = 1'b1;
        tick();
        cfg_baud_wr = 1'b0;
        check("defer_busy", cfg_busy, 1);
        for (int c = 0; c < 3; c++) tick();
        check("defer_baud_send", baud, model_baud);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("defer_baud_m1", baud, model_baud);
        tick();
        check("defer_baud_m2", baud, 115200);
        check("defer_no_gnt", gnt, 0);
        bad = 1'b0;
        for (int c = 0; c < SETTLE_CYC - 1; c++) begin
            tick();
            if (gnt != 4'b0000 || cfg_busy != 1'b1) bad = 1'b1;
        end
        check("defer_settle_hold", bad, 0);
        tick();
        check("defer_busy_fall", {cfg_busy, gnt}, 0);
        tick();
        check("defer_late_gnt", gnt, 4'b0010);
        check("defer_late_data", tx_data, 8'h99);
        req = 4'b0000;
        model_baud = 17'd115200;

        // Reset mid-SEND with a baud change pending
        tick();
        cfg_baud = 17'd57600; cfg_baud_wr = 1'b1;
        tick();
        cfg_baud_wr = 1'b0;
        check("rst2_busy_pre", cfg_busy, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst2_gnt", {gnt, tx_start}, 0);
        check("rst2_tx_data", tx_data, 0);
        check("rst2_baud", baud, 9600);
        check("rst2_busy", cfg_busy, 0);
        check("rst2_errs", {cfg_err, tx_err}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        model_baud = 17'd9600;

        // Round-robin table, each vector from reset
        for (int v = 0; v < 2; v++) begin
            do_reset();
            req_data = {8'h13, 8'h12, 8'h11, 8'h10};
            req = rr_tab[v].req;
            for (int k = 0; k < rr_tab[v].n; k++) begin
                wait_gnt(lat);
                check("rr_latency", lat, (k == 0) ? 1 : 2);
                check("rr_gnt", gnt, 4'b0001 << rr_tab[v].idx[k]);
                check("rr_data", tx_data, 8'h10 + rr_tab[v].idx[k]);
                if (k == rr_tab[v].n - 1) req = 4'b0000;
                for (int c = 0; c < 5; c++) tick();
                tx_done = 1'b1;
            end
            tick();
            tx_done = 1'b0;
        end

        // Timeout abort, then tx_done on the timeout cycle
        do_reset();
        req = 4'b0001; req_data = {24'h0, 8'hE1};
        wait_gnt(lat);
        check("tmo_gnt", gnt, 4'b0001);
        req = 4'b0000;
        for (int c = 0; c < TMO_CYC - 1; c++) tick();
        check("tmo_early", tx_err, 0);
        tick();
        check("tmo_err", tx_err, 1);
        req = 4'b0001; req_data = {24'h0, 8'hE2};
        tick();
        check("tmo_err_pulse", tx_err, 0);
        check("tmo_idle_gnt", gnt, 4'b0001);
        check("tmo_idle_data", tx_data, 8'hE2);
        req = 4'b0000;
        for (int c = 0; c < TMO_CYC - 1; c++) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("tmo_done_wins", tx_err, 0);
        req = 4'b0001; req_data = {24'h0, 8'hE3};
        tick();
        check("tmo_done_idle_gnt", gnt, 4'b0001);
        check("tmo_done_no_err", tx_err, 0);
        req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler for the UART block. It shares one UART transmitter among `NREQ` requesters using round-robin arbitration, one byte per grant. It also owns the baud setting that drives the baud clock generator. Baud changes are validated and applied only while the transmitter is idle, followed by a settle interval so the generator's counters re-lock before the next byte starts.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `SETTLE_CYC`, 32, idle cycles held after applying a new baud
- `TMO_CYC`, 250000, max `clk` cycles from `tx_start` to `tx_done` before abort
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `req` in NREQ: requester i has a byte pending; held high with data stable until `gnt[i]`
- `req_data` in NREQ*8: byte of requester i at bits [8i+7:8i]
- `gnt` out NREQ: one-hot, 1-cycle pulse; byte of i consumed
- `tx_start` out 1: 1-cycle pulse to transmitter, coincident with `gnt`
- `tx_data` out 8: byte being sent; held stable through SEND
- `tx_done` in 1: 1-cycle pulse from transmitter, frame complete
- `cfg_baud_wr` in 1: baud write strobe
- `cfg_baud` in 17: requested baud rate
- `cfg_busy` out 1: baud change pending or settling; writes ignored
- `cfg_err` out 1: 1-cycle pulse, unsupported baud rejected
- `tx_err` out 1: 1-cycle pulse, timeout abort
- `baud` out 17: registered baud to the clock generator

## Operation
- Reset values: `gnt`=0, `tx_start`=0, `tx_data`=0, `baud`=9600, `cfg_busy`=0, `cfg_err`=0, `tx_err`=0, state IDLE, RR pointer=NREQ-1 (requester 0 wins first).
- Supported bauds: 4800, 9600, 14400, 19200, 38400, 57600, 115200, 128000.
- Config write with `cfg_busy`=0:
  - Supported value: latched into a pending register; `cfg_busy`=1 from the next cycle.
  - Unsupported value: `cfg_err` pulses the next cycle; nothing latched; `baud` unchanged.
  - Writes while `cfg_busy`=1 are ignored, with no `cfg_err`.
- States:
  - IDLE:
    - If a baud change is pending, go to BAUD. Baud has priority over `req`.
    - Otherwise, if `|req`, the winner is the first set bit searching upward from pointer+1, mod NREQ. Go to GRANT.
  - GRANT (1 cycle):
    - `gnt[w]`=1 and `tx_start`=1.
    - `tx_data`=`req_data[w]`, latched this cycle.
    - Pointer←w. Go to SEND.
  - SEND:
    - Timeout counter cleared on entry, +1 per cycle.
    - `tx_done`=1: go to IDLE.
    - Counter reaches TMO_CYC-1 without `tx_done`: `tx_err` pulses, go to IDLE; the byte is dropped, not retried.
    - `tx_done` and timeout in the same cycle: done wins, no `tx_err`.
  - BAUD:
    - `baud`←pending on entry cycle.
    - Settle counter runs SETTLE_CYC cycles, then go to IDLE.
    - `cfg_busy` falls in the same cycle IDLE is re-entered.
- `tx_done` outside SEND is ignored.
- `req` deasserted before grant is legal. The winner is evaluated only in IDLE.
- `rst_n` low at any time clears all state immediately. A pending baud change is lost; `baud` returns to 9600.

## Timing
- Grant latency: `req` sampled high in IDLE at cycle N gives `gnt`/`tx_start` at N+1.
- Back-to-back: `tx_done` at cycle M gives IDLE at M+1 and next `gnt` at M+2.
- Config: write at cycle N gives `cfg_busy`=1 at N+1.
  - If IDLE at N+1: BAUD at N+2 with `baud` updated at N+2; `cfg_busy`=0 at N+2+SETTLE_CYC.
  - If SEND: deferred until after `tx_done`.
- `tx_data` stable from GRANT until leaving SEND.
- All outputs registered; no combinational input→output paths.

## Test plan
- Reset: `rst_n` low mid-SEND with `cfg_busy`=1 -> all outputs at reset values; `baud`=9600; first grant after release goes to req0.
- Single requester: `req`=0001, `req_data`=0x5A -> `gnt`=0001 and `tx_start` 1 cycle later with `tx_data`=0x5A; `tx_done` after 20 cycles -> next `gnt` 2 cycles after `tx_done`.
- Round-robin: `req`=1111 held, `tx_done` 5 cycles after each `tx_start` -> grant order 0,1,2,3,0; `req`=1010 from reset -> order 1,3,1.
- Deferred baud: write 115200 during SEND -> `baud` stays 9600 until the cycle after `tx_done`+1; `cfg_busy` high SETTLE_CYC+ cycles; pending `req` granted only after `cfg_busy` falls.
- Invalid baud: write 12345 while idle -> `cfg_err` 1-cycle pulse, `baud` unchanged, `cfg_busy` stays 0; second write while busy -> ignored.
- Timeout: TMO_CYC=100, no `tx_done` -> `tx_err` pulse 100 cycles after `tx_start`, return to IDLE; `tx_done` arriving on the timeout cycle -> no `tx_err`.
